// File: rtl/pokey_mix_pkg.sv
// Shared definitions for the POKEY stereo mixer: config byte layout, routing codes,
// and a constant-safe ceil(log2) helper.
package pokey_mix_pkg;

  localparam int unsigned MUTE_BIT  = 7;
  localparam int unsigned ROUTE_LSB = 2;
  localparam int unsigned ATT_LSB   = 0;

  localparam logic [7:0] CFG_RESET = 8'h0C;

  typedef enum logic [1:0] {
    RouteOff   = 2'b00,
    RouteLeft  = 2'b01,
    RouteRight = 2'b10,
    RouteBoth  = 2'b11
  } route_e;

  typedef struct packed {
    logic       mute;
    route_e     route;
    logic [1:0] att;
  } cfg_t;

  // Bits 6:4 of the config byte carry no meaning and are dropped here.
  function automatic cfg_t cfg_decode(input logic [7:0] b);
    cfg_t c;
    c.mute  = b[MUTE_BIT];
    c.route = route_e'(b[ROUTE_LSB +: 2]);
    c.att   = b[ATT_LSB +: 2];
    return c;
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mix_adder_tree.sv
// Registered pairwise-add tree with a matching valid pipe; leaves beyond N read as zero.
module mix_adder_tree
  import pokey_mix_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IN_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [N*IN_W-1:0]         terms,
  output logic                      valid_out,
  output logic [IN_W+clog2(N)-1:0]  sum
);

  localparam int unsigned LEVELS = clog2(N);
  localparam int unsigned SUM_W  = IN_W + LEVELS;
  localparam int unsigned NP     = 1 << LEVELS;

  if (LEVELS == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign sum            = terms;
    assign valid_out      = valid_in;
  end else begin : g_tree
    logic [SUM_W-1:0]  src    [LEVELS][NP];
    logic [SUM_W-1:0]  node_q [LEVELS][NP/2];
    logic [LEVELS-1:0] vld_q;

    // src[l] is the input row of level l: padded leaves, then the previous level's sums.
    always_comb begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int j = 0; j < NP; j++) src[l][j] = '0;
      end
      for (int j = 0; j < N; j++) src[0][j] = SUM_W'(terms[j*IN_W +: IN_W]);
      for (int l = 1; l < LEVELS; l++) begin
        for (int j = 0; j < NP/2; j++) src[l][j] = node_q[l-1][j];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int l = 0; l < LEVELS; l++) begin
          for (int j = 0; j < NP/2; j++) node_q[l][j] <= '0;
        end
      end else begin
        vld_q <= (vld_q << 1) | LEVELS'(valid_in);
        for (int l = 0; l < LEVELS; l++) begin
          for (int j = 0; j < NP/2; j++) begin
            if (j < (NP >> (l + 1))) node_q[l][j] <= src[l][2*j] + src[l][2*j+1];
            else                     node_q[l][j] <= '0;
          end
        end
      end
    end

    assign sum       = node_q[LEVELS-1][0];
    assign valid_out = vld_q[LEVELS-1];
  end

endmodule

// File: rtl/pokey_audio_mixer.sv
// Stereo POKEY mixer: per-channel mute/attenuate/route, registered adder trees,
// saturating output stage and a pair of PWM DAC pins.
module pokey_audio_mixer
  import pokey_mix_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 4,
  parameter int unsigned OUT_W  = 6,
  parameter int unsigned CA_W   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_CH*CH_W-1:0] aud_in,
  input  logic                   cfg_we,
  input  logic [CA_W-1:0]        cfg_addr,
  input  logic [7:0]             cfg_data,
  output logic [OUT_W-1:0]       audio_l,
  output logic [OUT_W-1:0]       audio_r,
  output logic                   out_valid,
  output logic                   clip_l,
  output logic                   clip_r,
  output logic                   pwm_l,
  output logic                   pwm_r
);

  localparam int unsigned LEVELS  = clog2(NUM_CH);
  localparam int unsigned SUM_W   = CH_W + LEVELS;
  localparam int unsigned OUT_MAX = (1 << OUT_W) - 1;

  cfg_t                   cfg_q [NUM_CH];
  logic [NUM_CH*CH_W-1:0] term_l_d, term_r_d, term_l_q, term_r_q;
  logic [CH_W-1:0]        v;
  logic                   vld0_q, vld_l, vld_r;
  logic [SUM_W-1:0]       sum_l, sum_r;
  logic                   sat_l, sat_r;
  logic [OUT_W-1:0]       audio_l_q, audio_r_q, cnt_q, duty_l_q, duty_r_q;
  logic                   out_valid_q, clip_l_q, clip_r_q, pwm_l_q, pwm_r_q;

  // Stage 0 samples cfg_q before a same-cycle write lands, so that sample keeps the old config.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cfg_q[i] <= cfg_decode(CFG_RESET);
    end else if (cfg_we && (32'(cfg_addr) < NUM_CH)) begin
      cfg_q[cfg_addr] <= cfg_decode(cfg_data);
    end
  end

  always_comb begin
    term_l_d = '0;
    term_r_d = '0;
    v        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      v = cfg_q[i].mute ? '0 : (aud_in[i*CH_W +: CH_W] >> cfg_q[i].att);
      if (cfg_q[i].route inside {RouteLeft, RouteBoth})  term_l_d[i*CH_W +: CH_W] = v;
      if (cfg_q[i].route inside {RouteRight, RouteBoth}) term_r_d[i*CH_W +: CH_W] = v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld0_q   <= 1'b0;
      term_l_q <= '0;
      term_r_q <= '0;
    end else begin
      vld0_q <= en;
      if (en) begin
        term_l_q <= term_l_d;
        term_r_q <= term_r_d;
      end
    end
  end

  mix_adder_tree #(.N(NUM_CH), .IN_W(CH_W)) u_tree_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (vld0_q),
    .terms     (term_l_q),
    .valid_out (vld_l),
    .sum       (sum_l)
  );

  mix_adder_tree #(.N(NUM_CH), .IN_W(CH_W)) u_tree_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (vld0_q),
    .terms     (term_r_q),
    .valid_out (vld_r),
    .sum       (sum_r)
  );

  assign sat_l = 32'(sum_l) > OUT_MAX;
  assign sat_r = 32'(sum_r) > OUT_MAX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      clip_l_q    <= 1'b0;
      clip_r_q    <= 1'b0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
    end else begin
      out_valid_q <= vld_l && vld_r;
      clip_l_q    <= vld_l && sat_l;
      clip_r_q    <= vld_r && sat_r;
      if (vld_l) audio_l_q <= sat_l ? OUT_W'(OUT_MAX) : OUT_W'(sum_l);
      if (vld_r) audio_r_q <= sat_r ? OUT_W'(OUT_MAX) : OUT_W'(sum_r);
    end
  end

  // Duty reloads only at the end of a period so each PWM period is a single clean pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      duty_l_q <= '0;
      duty_r_q <= '0;
      pwm_l_q  <= 1'b0;
      pwm_r_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + OUT_W'(1);
      pwm_l_q <= cnt_q < duty_l_q;
      pwm_r_q <= cnt_q < duty_r_q;
      if (cnt_q == '1) begin
        duty_l_q <= audio_l_q;
        duty_r_q <= audio_r_q;
      end
    end
  end

  assign audio_l   = audio_l_q;
  assign audio_r   = audio_r_q;
  assign out_valid = out_valid_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign pwm_l     = pwm_l_q;
  assign pwm_r     = pwm_r_q;

endmodule

// File: tb/tb_pokey_audio_mixer.sv
// Self-checking bench: a 4-channel/6-bit mixer and a 3-channel/5-bit mixer against a
// plain-arithmetic mixing model.
module tb_pokey_audio_mixer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int l; int r; int cl; int cr; int t; } res_t;

  logic        en_a = 1'b0, we_a = 1'b0;
  logic [15:0] aud_a = '0;
  logic [1:0]  addr_a = '0;
  logic [7:0]  data_a = '0;
  logic [5:0]  l_a, r_a;
  logic        ov_a, cl_a, cr_a, pl_a, pr_a;

  logic        en_b = 1'b0, we_b = 1'b0;
  logic [11:0] aud_b = '0;
  logic [1:0]  addr_b = '0;
  logic [7:0]  data_b = '0;
  logic [4:0]  l_b, r_b;
  logic        ov_b, cl_b, cr_b, pl_b, pr_b;

  pokey_audio_mixer #(.NUM_CH(4), .CH_W(4), .OUT_W(6), .CA_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .aud_in(aud_a), .cfg_we(we_a), .cfg_addr(addr_a),
    .cfg_data(data_a), .audio_l(l_a), .audio_r(r_a), .out_valid(ov_a), .clip_l(cl_a),
    .clip_r(cr_a), .pwm_l(pl_a), .pwm_r(pr_a)
  );

  pokey_audio_mixer #(.NUM_CH(3), .CH_W(4), .OUT_W(5), .CA_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .aud_in(aud_b), .cfg_we(we_b), .cfg_addr(addr_b),
    .cfg_data(data_b), .audio_l(l_b), .audio_r(r_b), .out_valid(ov_b), .clip_l(cl_b),
    .clip_r(cr_b), .pwm_l(pl_b), .pwm_r(pr_b)
  );

  int         checks = 0, errors = 0, cyc = 0;
  logic [7:0] cfg_a [4];
  logic [7:0] cfg_b [4];
  res_t       obs_a[$], obs_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov_a) obs_a.push_back('{int'(l_a), int'(r_a), int'(cl_a), int'(cr_a), cyc});
    if (ov_b) obs_b.push_back('{int'(l_b), int'(r_b), int'(cl_b), int'(cr_b), cyc});
  end

  // Mixing rules straight from the channel description: mute, divide by 2^att, route, clamp.
  function automatic res_t model(input int n, input int ow, input logic [7:0] cfg [4],
                                 input logic [15:0] smp, input int t);
    res_t e;
    int sl, sr, v, maxv;
    logic [1:0] route;
    sl = 0; sr = 0;
    maxv = (1 << ow) - 1;
    for (int i = 0; i < n; i++) begin
      route = cfg[i][3:2];
      v = cfg[i][7] ? 0 : int'(smp[i*4 +: 4]) / (1 << cfg[i][1:0]);
      if (route == 2'b01 || route == 2'b11) sl += v;
      if (route == 2'b10 || route == 2'b11) sr += v;
    end
    e.cl = int'(sl > maxv);
    e.cr = int'(sr > maxv);
    e.l  = e.cl ? maxv : sl;
    e.r  = e.cr ? maxv : sr;
    e.t  = t;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_models();
    for (int i = 0; i < 4; i++) begin
      cfg_a[i] = 8'h0C;
      cfg_b[i] = 8'h0C;
    end
  endtask

  task automatic wait_obs(input bit side_b, input int n, input int budget);
    for (int w = 0; w < budget; w++) begin
      if ((side_b ? obs_b.size() : obs_a.size()) >= n) break;
      tick();
    end
  endtask

  task automatic cfg_write_a(input logic [1:0] addr, input logic [7:0] data);
    we_a = 1'b1; addr_a = addr; data_a = data;
    tick();
    we_a = 1'b0;
    cfg_a[addr] = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({l_a, r_a, ov_a, cl_a, cr_a, pl_a, pr_a} !== '0) begin
      errors++; $display("FAIL reset_a outputs got %h want 0", {l_a, r_a, ov_a, cl_a, cr_a, pl_a, pr_a});
    end
    checks++;
    if ({l_b, r_b, ov_b, cl_b, cr_b, pl_b, pr_b} !== '0) begin
      errors++; $display("FAIL reset_b outputs got %h want 0", {l_b, r_b, ov_b, cl_b, cr_b, pl_b, pr_b});
    end
    rst_n = 1'b1;
    reset_models();
    obs_a.delete(); obs_b.delete();
    repeat (8) tick();
    checks++;
    if (obs_a.size() + obs_b.size() != 0) begin
      errors++; $display("FAIL reset_idle out_valid pulses got %0d want 0", obs_a.size() + obs_b.size());
    end
  endtask

  task automatic test_defaults();
    res_t e, o;
    obs_a.delete();
    aud_a = 16'hFFFF; en_a = 1'b1;
    e = model(4, 6, cfg_a, aud_a, cyc);
    tick();
    en_a = 1'b0;
    wait_obs(1'b0, 1, 12);
    checks++;
    if (obs_a.size() < 1) begin
      errors++; $display("FAIL defaults_timeout results got %0d want 1", obs_a.size());
    end else begin
      o = obs_a.pop_front();
      checks++;
      if (o.l !== e.l || o.r !== e.r || o.cl !== e.cl || o.cr !== e.cr || o.t - e.t != 4) begin
        errors++; $display("FAIL defaults got l=%0d r=%0d cl=%0d cr=%0d lat=%0d want %0d %0d %0d %0d 4",
                           o.l, o.r, o.cl, o.cr, o.t - e.t, e.l, e.r, e.cl, e.cr);
      end
      checks++;
      if (o.l !== 60 || o.r !== 60) begin
        errors++; $display("FAIL defaults_mono got l=%0d r=%0d want 60 60", o.l, o.r);
      end
    end
  endtask

  task automatic test_routing();
    res_t e, o;
    cfg_write_a(2'd0, 8'h04);
    cfg_write_a(2'd1, 8'h08);
    cfg_write_a(2'd2, 8'h80);
    cfg_write_a(2'd3, 8'h0E);
    obs_a.delete();
    aud_a = 16'hCF58; en_a = 1'b1;
    e = model(4, 6, cfg_a, aud_a, cyc);
    tick();
    en_a = 1'b0;
    wait_obs(1'b0, 1, 12);
    checks++;
    if (obs_a.size() < 1) begin
      errors++; $display("FAIL routing_timeout results got %0d want 1", obs_a.size());
    end else begin
      o = obs_a.pop_front();
      checks++;
      if (o.l !== e.l || o.r !== e.r || o.cl !== e.cl || o.cr !== e.cr) begin
        errors++; $display("FAIL routing got l=%0d r=%0d cl=%0d cr=%0d want %0d %0d %0d %0d",
                           o.l, o.r, o.cl, o.cr, e.l, e.r, e.cl, e.cr);
      end
      checks++;
      if (o.l !== 11 || o.r !== 8) begin
        errors++; $display("FAIL routing_const got l=%0d r=%0d want 11 8", o.l, o.r);
      end
    end
  endtask

  // Random samples on every clock with random config writes, some landing on an en cycle.
  task automatic test_back_to_back();
    res_t exp_q[$];
    res_t e, o;
    int n;
    n = 24;
    obs_a.delete();
    for (int k = 0; k < n; k++) begin
      aud_a  = 16'($urandom);
      en_a   = 1'b1;
      we_a   = ($urandom_range(0, 2) == 0);
      addr_a = 2'($urandom);
      data_a = 8'($urandom);
      exp_q.push_back(model(4, 6, cfg_a, aud_a, cyc));
      tick();
      if (we_a) cfg_a[addr_a] = data_a;
    end
    en_a = 1'b0; we_a = 1'b0;
    wait_obs(1'b0, n, 20);
    repeat (6) tick();
    checks++;
    if (obs_a.size() != n) begin
      errors++; $display("FAIL b2b_count results got %0d want %0d", obs_a.size(), n);
    end
    for (int k = 0; k < n && obs_a.size() > 0; k++) begin
      o = obs_a.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.l !== e.l || o.r !== e.r || o.cl !== e.cl || o.cr !== e.cr || o.t - e.t != 4) begin
        errors++; $display("FAIL b2b[%0d] got l=%0d r=%0d cl=%0d cr=%0d lat=%0d want %0d %0d %0d %0d 4",
                           k, o.l, o.r, o.cl, o.cr, o.t - e.t, e.l, e.r, e.cl, e.cr);
      end
    end
  endtask

  task automatic test_same_cycle_b();
    res_t exp_q[$];
    res_t e, o;
    obs_b.delete();
    we_b = 1'b1; addr_b = 2'd0; data_b = 8'h80;
    en_b = 1'b1; aud_b = 12'h009;
    exp_q.push_back(model(3, 5, cfg_b, {4'h0, aud_b}, cyc));
    tick();
    cfg_b[0] = 8'h80;
    we_b = 1'b0;
    exp_q.push_back(model(3, 5, cfg_b, {4'h0, aud_b}, cyc));
    tick();
    en_b = 1'b0;
    // Address 3 is beyond the 3 channels and must not change anything.
    we_b = 1'b1; addr_b = 2'd3; data_b = 8'h80;
    tick();
    addr_b = 2'd0; data_b = 8'h0C;
    tick();
    we_b = 1'b0;
    cfg_b[0] = 8'h0C;
    en_b = 1'b1; aud_b = 12'h777;
    exp_q.push_back(model(3, 5, cfg_b, {4'h0, aud_b}, cyc));
    tick();
    en_b = 1'b0;
    wait_obs(1'b1, 3, 12);
    checks++;
    if (obs_b.size() != 3) begin
      errors++; $display("FAIL same_cycle_count results got %0d want 3", obs_b.size());
    end
    for (int k = 0; k < 3 && obs_b.size() > 0; k++) begin
      o = obs_b.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.l !== e.l || o.r !== e.r || o.cl !== e.cl || o.cr !== e.cr) begin
        errors++; $display("FAIL same_cycle[%0d] got l=%0d r=%0d cl=%0d cr=%0d want %0d %0d %0d %0d",
                           k, o.l, o.r, o.cl, o.cr, e.l, e.r, e.cl, e.cr);
      end
      checks++;
      if (k < 2 && o.l !== ((k == 0) ? 9 : 0)) begin
        errors++; $display("FAIL same_cycle_const[%0d] got l=%0d want %0d", k, o.l, (k == 0) ? 9 : 0);
      end
    end
  endtask

  task automatic test_clip_b();
    res_t e0, e1, o;
    obs_b.delete();
    en_b = 1'b1; aud_b = 12'hFFF;
    e0 = model(3, 5, cfg_b, {4'h0, aud_b}, cyc);
    tick();
    aud_b = 12'h000;
    e1 = model(3, 5, cfg_b, {4'h0, aud_b}, cyc);
    tick();
    en_b = 1'b0;
    wait_obs(1'b1, 2, 12);
    checks++;
    if (obs_b.size() < 2) begin
      errors++; $display("FAIL clip_timeout results got %0d want 2", obs_b.size());
    end else begin
      o = obs_b.pop_front();
      checks++;
      if (o.l !== 31 || o.r !== 31 || o.cl !== 1 || o.cr !== 1 || o.l !== e0.l || o.t - e0.t != 4) begin
        errors++; $display("FAIL clip_sat got l=%0d r=%0d cl=%0d cr=%0d lat=%0d want 31 31 1 1 4",
                           o.l, o.r, o.cl, o.cr, o.t - e0.t);
      end
      o = obs_b.pop_front();
      checks++;
      if (o.l !== e1.l || o.r !== e1.r || o.cl !== 0 || o.cr !== 0) begin
        errors++; $display("FAIL clip_zero got l=%0d r=%0d cl=%0d cr=%0d want 0 0 0 0",
                           o.l, o.r, o.cl, o.cr);
      end
    end
  endtask

  task automatic test_ramp_reset();
    res_t o;
    int t0;
    for (int i = 0; i < 4; i++) cfg_write_a(2'(i), 8'h0C);
    obs_a.delete();
    t0 = cyc;
    for (int k = 1; k <= 6; k++) begin
      en_a = 1'b1; aud_a = {4{4'(k)}};
      tick();
    end
    en_a = 1'b0;
    wait_obs(1'b0, 6, 12);
    checks++;
    if (obs_a.size() != 6) begin
      errors++; $display("FAIL ramp_count results got %0d want 6", obs_a.size());
    end
    for (int k = 1; k <= 6 && obs_a.size() > 0; k++) begin
      o = obs_a.pop_front();
      checks++;
      if (o.l !== 4 * k || o.r !== 4 * k || o.t !== t0 + 3 + k) begin
        errors++; $display("FAIL ramp[%0d] got l=%0d r=%0d t=%0d want %0d %0d %0d",
                           k, o.l, o.r, o.t, 4 * k, 4 * k, t0 + 3 + k);
      end
    end
    for (int k = 0; k < 3; k++) begin
      en_a = 1'b1; aud_a = 16'h3333;
      tick();
    end
    en_a = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({l_a, r_a, ov_a, cl_a, cr_a} !== '0) begin
      errors++; $display("FAIL midreset_outputs got %h want 0", {l_a, r_a, ov_a, cl_a, cr_a});
    end
    tick();
    rst_n = 1'b1;
    reset_models();
    repeat (10) tick();
    checks++;
    if (obs_a.size() != 0) begin
      errors++; $display("FAIL midreset_flush out_valid pulses got %0d want 0", obs_a.size());
    end
  endtask

  task automatic test_pwm();
    res_t e, eb, o;
    int hl, hr;
    obs_a.delete(); obs_b.delete();
    for (int pass = 0; pass < 2; pass++) begin
      aud_a = (pass == 0) ? 16'h001F : 16'h0000;
      en_a = 1'b1;
      e = model(4, 6, cfg_a, aud_a, cyc);
      tick();
      en_a = 1'b0;
      wait_obs(1'b0, 1, 12);
      checks++;
      if (obs_a.size() < 1) begin
        errors++; $display("FAIL pwm_timeout[%0d] results got 0 want 1", pass);
      end else begin
        o = obs_a.pop_front();
        checks++;
        if (o.l !== e.l || o.l !== ((pass == 0) ? 16 : 0)) begin
          errors++; $display("FAIL pwm_audio[%0d] got l=%0d want %0d", pass, o.l, e.l);
        end
      end
      repeat (70) tick();
      hl = 0; hr = 0;
      for (int c = 0; c < 64; c++) begin
        hl += int'(pl_a); hr += int'(pr_a);
        tick();
      end
      checks++;
      if (hl !== e.l || hr !== e.r) begin
        errors++; $display("FAIL pwm_duty[%0d] got high l=%0d r=%0d of 64 want %0d %0d",
                           pass, hl, hr, e.l, e.r);
      end
    end
    en_b = 1'b1; aud_b = 12'hFFF;
    eb = model(3, 5, cfg_b, {4'h0, aud_b}, cyc);
    tick();
    en_b = 1'b0;
    repeat (45) tick();
    hl = 0;
    for (int c = 0; c < 32; c++) begin
      hl += int'(pl_b);
      tick();
    end
    checks++;
    if (hl !== eb.l || hl !== 31) begin
      errors++; $display("FAIL pwm_max got high %0d of 32 want %0d", hl, eb.l);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_models();
    test_reset();
    test_defaults();
    test_routing();
    test_back_to_back();
    test_same_cycle_b();
    test_clip_b();
    test_ramp_reset();
    test_pwm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pokey_audio_mixer.md
Name: pokey_audio_mixer

Overview:
Parametrised successor to the fixed 4-channel POKEY audio summer. It takes NUM_CH channel samples and applies a per-channel mute, a right-shift attenuation and left/right routing to each. It sums the channels through a registered adder tree into stereo outputs, saturates each sum to OUT_W bits, and drives a pair of PWM DAC pins. It sits after the aud_control channels and is written by the IO core on the chip enable strobe.

Parameters:
NUM_CH, 4, number of input channels (1..16)
CH_W, 4, width of each unsigned channel sample
OUT_W, 6, width of each output sample and of the PWM counter (2..12)
CA_W, 2, config address width; must satisfy 2^CA_W >= NUM_CH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  sample strobe, one clk wide (enn pulse)
aud_in  in  NUM_CH*CH_W  channel samples; channel i occupies bits [i*CH_W +: CH_W]
cfg_we  in  1  config write strobe
cfg_addr  in  CA_W  channel index to configure
cfg_data  in  8  config byte
audio_l  out  OUT_W  left mixed sample
audio_r  out  OUT_W  right mixed sample
out_valid  out  1  one-clk pulse when audio_l/audio_r update
clip_l  out  1  one-clk pulse with out_valid when the left sum saturated
clip_r  out  1  same for the right sum
pwm_l  out  1  left PWM DAC output
pwm_r  out  1  right PWM DAC output

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset: every output is 0, the pipeline is empty (no out_valid), the PWM counter and duty registers are 0.
- Reset value of every channel config is 0x0C: not muted, shift 0, routed to both sides. Defaults therefore reproduce the legacy mono sum.
- Config byte layout:
  - bit7 = mute.
  - bits3:2 = route: 00 off, 01 left, 10 right, 11 both.
  - bits1:0 = attenuation, a right-shift of 0..3.
  - Remaining bits are ignored.
- Config writes:
  - A cfg_we with cfg_addr >= NUM_CH is ignored.
  - A config write affects samples whose en falls in the cycle after the write or later.
  - When cfg_we and en occur in the same cycle, that sample uses the old config.
- Stage 0 (when en is high): per channel, v = mute ? 0 : aud_in_i >> shift. The left term is v if the route includes left, else 0; the right term follows the same rule. Terms are registered and a valid bit is set.
- Tree stages:
  - ceil(log2 NUM_CH) registered pairwise-add levels per side; the valid bit travels alongside.
  - Non-power-of-2 channel counts are padded with zero terms.
  - Sum width is CH_W + ceil(log2 NUM_CH); no intermediate overflow is possible.
- Output stage:
  - If sum > 2^OUT_W - 1, the output is 2^OUT_W - 1 and the clip flag pulses; otherwise the output is the zero-extended sum.
  - audio_l/r update only with out_valid and hold their value between updates.
- Latency: out_valid pulses exactly ceil(log2 NUM_CH) + 2 clocks after en (4 for the defaults, 2 for NUM_CH=1).
- Throughput: back-to-back en (every clock) is supported with one result per clock.
- PWM:
  - An OUT_W-bit counter increments every clk and wraps from max to 0.
  - duty_l/r load audio_l/r on the cycle the counter equals max, so duty changes are glitch-free at period boundaries.
  - pwm_x = (cnt < duty_x), registered.
  - Duty 0 keeps the pin low; duty max gives high for 2^OUT_W - 1 of 2^OUT_W clocks.
- Reset mid-pipeline: in-flight samples are discarded and no out_valid is produced for them.

Decomposition:
- Shared package pokey_mix_pkg: config bit positions (MUTE_BIT=7, ROUTE_LSB=2, ATT_LSB=0), route encodings, CFG_RESET=8'h0C, and a clog2 function.
- One natural sub-module, mix_adder_tree: a parametrised registered pairwise-add tree with a valid pipe, instantiated once per side.
- The PWM logic stays inline.

Test Plan:
- Defaults, all four channels = 15, en pulse -> 4 clocks later out_valid=1, audio_l=audio_r=60, clip_l=clip_r=0.
- Config ch0=0x04 (left only), ch1=0x08 (right only), ch2=0x80 (muted), ch3=0x0E (both, shift 2); inputs 8,5,15,12 -> audio_l=11, audio_r=8.
- OUT_W=5, all four channels = 15 -> audio_l=audio_r=31, clip_l=clip_r pulse with out_valid; a following all-zero sample gives 0 with no clip.
- Same-cycle cfg_we(ch0=0x80) and en with ch0=9 and others 0 -> that result is 9; the next sample's result is 0. A write to cfg_addr=3 with NUM_CH=3 is ignored.
- en asserted on 6 consecutive clocks with a ramping input -> 6 consecutive out_valid pulses in order; rst_n asserted mid-stream -> outputs 0 at once and no further out_valid.
- PWM with OUT_W=6: audio_l=16 -> pwm_l high for 16 of every 64 clocks once the period boundary passes; audio_l=0 -> constant low.
